// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle shared between a master/bridge and the register-file slave.
// Clock and reset are kept outside the bundle as plain ports.
interface apb_slave_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// Parametrised APB register-file slave: read-only ID at index 0, byte strobes,
// programmable wait states and PSLVERR on decode errors.
module apb_slave_regfile #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                pclk,
  input  logic                preset,
  apb_slave_regfile_if.slave  apb
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int REG_W = $clog2(DEPTH);

  localparam logic [IDX_W:0]       DEPTH_V   = (IDX_W + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ID_WORD  = DATA_WIDTH'(ID_VALUE);
  localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [REG_W-1:0]      hold_idx;
  logic                  hold_write;
  logic                  hold_err;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_err;
  logic [DATA_WIDTH-1:0] cur_rdata;
  logic                  enter_ready;
  logic                  commit;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] merged;

  // Byte offset bits of paddr never influence decoding.
  if (OFF_W > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = &{1'b0, apb.paddr[OFF_W-1:0]};
  end

  // Expand the byte strobes into a bit mask for the write merge.
  for (genvar g = 0; g < BYTES; g++) begin : g_mask
    assign byte_mask[8*g +: 8] = {8{apb.pstrb[g]}};
  end

  // Decode the current address into a register index, error flag and read value.
  always_comb begin
    cur_idx   = apb.paddr[ADDR_WIDTH-1:OFF_W];
    cur_err   = ({1'b0, cur_idx} >= DEPTH_V) || (apb.pwrite && (cur_idx == '0));
    cur_rdata = '0;
    if (cur_idx == '0) begin
      cur_rdata = ID_WORD;
    end else if ({1'b0, cur_idx} < DEPTH_V) begin
      cur_rdata = regs[cur_idx[REG_W-1:0]];
    end
  end

  // Work out when the FSM moves into READY and when a write is committed.
  always_comb begin
    enter_ready = apb.psel &&
                  (((state == S_IDLE) && !apb.penable && (WAIT_STATES == 0)) ||
                   ((state == S_WAIT) && apb.penable && (wait_cnt == 4'd1)));
    commit      = (state == S_READY) && apb.psel && apb.penable && hold_write && !hold_err;
    merged      = (regs[hold_idx] & ~byte_mask) | (apb.pwdata & byte_mask);
  end

  // Transfer FSM with registered response outputs; deselect aborts any transfer.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      hold_idx   <= '0;
      hold_write <= 1'b0;
      hold_err   <= 1'b0;
    end else if (!apb.psel) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else if (enter_ready) begin
      state      <= S_READY;
      wait_cnt   <= '0;
      pready_q   <= 1'b1;
      pslverr_q  <= cur_err;
      prdata_q   <= apb.pwrite ? '0 : cur_rdata;
      hold_idx   <= cur_idx[REG_W-1:0];
      hold_write <= apb.pwrite;
      hold_err   <= cur_err;
    end else begin
      case (state)
        S_IDLE: begin
          if (!apb.penable) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (apb.penable) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_READY: begin
          state     <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Register storage: cleared by reset, byte-merged on a completing good write.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      regs <= '{default: '0};
    end else if (commit) begin
      regs[hold_idx] <= merged;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one zero-wait and one three-wait instance,
// a scoreboard of expected responses and a small register model.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel0, psel3, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  apb_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus0 ();
  apb_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus3 ();

  assign bus0.psel    = psel0;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.psel    = psel3;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  apb_slave_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(0), .ID_VALUE(ID)
  ) dut0 (
    .pclk(pclk), .preset(preset), .apb(bus0)
  );

  apb_slave_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(3), .ID_VALUE(ID)
  ) dut3 (
    .pclk(pclk), .preset(preset), .apb(bus3)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       tag;
  } exp_t;

  int          tests    = 0;
  int          failures = 0;
  logic [31:0] model0 [16];
  logic [31:0] model3 [16];
  exp_t        sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic obsReady(input bit use3);
    return use3 ? bus3.pready : bus0.pready;
  endfunction

  task automatic clearModels();
    for (int i = 0; i < 16; i++) begin
      model0[i] = '0;
      model3[i] = '0;
    end
  endtask

  task automatic idle();
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    tick();
  endtask

  // Pop the expected response and compare it with what the DUT presents with pready high.
  task automatic checkOutput(input bit use3, input int waited);
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_pready"}, {31'b0, obsReady(use3)}, 32'd1);
    check({e.tag, "_pslverr"}, {31'b0, use3 ? bus3.pslverr : bus0.pslverr}, {31'b0, e.err});
    if (!e.wr) check({e.tag, "_prdata"}, use3 ? bus3.prdata : bus0.prdata, e.rdata);
    check({e.tag, "_waits"}, waited, e.waits);
  endtask

  // Drive one full APB transfer; the caller decides whether an idle cycle follows.
  task automatic applyStimulus(input bit use3, input bit wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input string tag);
    exp_t        e;
    int          idx;
    int          waited;
    logic [31:0] mask;
    idx     = int'(addr >> 2);
    e.wr    = wr;
    e.tag   = tag;
    e.waits = use3 ? 3 : 0;
    e.err   = (idx >= 16) || (wr && (idx == 0));
    if (idx == 0)      e.rdata = ID;
    else if (idx < 16) e.rdata = use3 ? model3[idx] : model0[idx];
    else               e.rdata = '0;
    sb.push_back(e);

    psel0   = !use3;
    psel3   = use3;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    tick();
    penable = 1'b1;
    waited  = 0;
    while ((obsReady(use3) !== 1'b1) && (waited < 20)) begin
      tick();
      waited++;
    end
    checkOutput(use3, waited);
    tick();
    if (wr && !e.err) begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
      if (use3) model3[idx] = (model3[idx] & ~mask) | (data & mask);
      else      model0[idx] = (model0[idx] & ~mask) | (data & mask);
    end
    check({tag, "_pready_drop"}, {31'b0, obsReady(use3)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModels();
    preset  = 1'b0;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    tick();
    tick();
    check("rst_pready0",  {31'b0, bus0.pready},  32'd0);
    check("rst_pslverr0", {31'b0, bus0.pslverr}, 32'd0);
    check("rst_prdata0",  bus0.prdata,           32'd0);
    check("rst_pready3",  {31'b0, bus3.pready},  32'd0);
    check("rst_pslverr3", {31'b0, bus3.pslverr}, 32'd0);
    check("rst_prdata3",  bus3.prdata,           32'd0);
    preset = 1'b1;
    idle();

    // Zero-wait reads of the ID and an empty register.
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, "rd_id");    idle();
    applyStimulus(1'b0, 1'b0, 8'h14, 32'h0, 4'h0, "rd_idx5");  idle();

    // Full and partial strobe writes with read-back.
    applyStimulus(1'b0, 1'b1, 8'h14, 32'hDEADBEEF, 4'b1111, "wr_full");  idle();
    applyStimulus(1'b0, 1'b0, 8'h14, 32'h0,        4'h0,    "rd_full");  idle();
    applyStimulus(1'b0, 1'b1, 8'h14, 32'h11223344, 4'b0101, "wr_strb");  idle();
    applyStimulus(1'b0, 1'b0, 8'h14, 32'h0,        4'h0,    "rd_strb");  idle();

    // Decode errors leave everything untouched.
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h12345678, 4'b1111, "wr_id_err"); idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0,        4'h0,    "rd_id_again"); idle();
    applyStimulus(1'b0, 1'b0, 8'h40, 32'h0,        4'h0,    "rd_oor_err"); idle();
    applyStimulus(1'b0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'b1111, "wr_oor_err"); idle();
    applyStimulus(1'b0, 1'b0, 8'h17, 32'h0,        4'h0,    "rd_idx5_unal"); idle();

    // Back-to-back write then read with no idle cycle between them.
    applyStimulus(1'b0, 1'b1, 8'h08, 32'hCAFEF00D, 4'b1111, "b2b_wr");
    applyStimulus(1'b0, 1'b0, 8'h08, 32'h0,        4'h0,    "b2b_rd");  idle();

    // Three wait states on the second instance.
    applyStimulus(1'b1, 1'b1, 8'h0C, 32'h12345678, 4'b1111, "ws3_wr");  idle();
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h0,        4'h0,    "ws3_rd");  idle();
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0,        4'h0,    "ws3_oor"); idle();

    // Reset in the middle of a wait-state write abandons it.
    psel3   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h1C;
    pwdata  = 32'h55AA55AA;
    pstrb   = 4'b1111;
    tick();
    penable = 1'b1;
    tick();
    preset  = 1'b0;
    tick();
    check("midrst_pready",  {31'b0, bus3.pready},  32'd0);
    check("midrst_pslverr", {31'b0, bus3.pslverr}, 32'd0);
    clearModels();
    preset = 1'b1;
    idle();
    applyStimulus(1'b1, 1'b0, 8'h1C, 32'h0, 4'h0, "midrst_rd_idx7"); idle();
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h0, 4'h0, "midrst_rd_idx3"); idle();
    applyStimulus(1'b0, 1'b0, 8'h14, 32'h0, 4'h0, "rst_rd_idx5");    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
